// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
// A grant is held for up to MAX_BURST accepted beats. It is released early if
// the owner drops its request. Priority then rotates to the index after the
// released owner. Every grant is followed by one IDLE cycle.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s1,
    output logic             s0,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Beat index at which a grant must be released.
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_reg;
    logic [1:0]  ptr_reg;
    logic [1:0]  sel_reg;
    logic [3:0]  cnt_reg;

    logic [3:0]  req_rot;
    logic [1:0]  pick_idx;
    logic        granted;
    logic        transfer;
    logic [WIDTH-1:0] in_arr [4];

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    // Rotate the request vector so that bit 0 is the current priority holder.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    // Find the first requester at or after ptr. The scan runs downward so that
    // the lowest rotated position wins.
    always_comb begin
        pick_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_idx = ptr_reg + 2'(k);
            end
        end
    end

    assign granted   = (state_reg == GRANT);
    assign out_valid = granted & req[sel_reg];
    assign transfer  = out_valid & out_ready;
    assign out_data  = in_arr[sel_reg];
    assign s1        = sel_reg[1];
    assign s0        = sel_reg[0];
    assign busy      = granted;

    // Acknowledge goes only to the granted owner, in the cycle its beat is taken.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ack
            assign ack[gi] = transfer & (sel_reg == 2'(gi));
        end
    endgenerate

    // Arbitration FSM: pick a new owner in IDLE, then count beats in GRANT
    // until the burst limit is reached or the owner drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            sel_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req != 4'd0) begin
                        sel_reg   <= pick_idx;
                        cnt_reg   <= 4'd0;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if ((transfer && cnt_reg == LAST_BEAT) || !req[sel_reg]) begin
                        state_reg <= IDLE;
                        ptr_reg   <= sel_reg + 2'd1;
                        cnt_reg   <= 4'd0;
                    end else if (transfer) begin
                        cnt_reg   <= cnt_reg + 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Each table row drives one clock cycle
// of stimulus and gives the outputs expected during that cycle. dut_a uses
// MAX_BURST=4. dut_b uses MAX_BURST=1 and is exercised by a hand-written
// sequence after the table.
module tb_mux4_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic [3:0] eack;
        logic [1:0] esel;
        logic       ebusy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [7:0] in0, in1, in2, in3;

    logic [3:0] ack_a, ack_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, s1_a, s0_a, s1_b, s0_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ack(ack_a), .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .s1(s1_a), .s0(s0_a), .busy(busy_a)
    );

    mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .ack(ack_b), .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .s1(s1_b), .s0(s0_b), .busy(busy_b)
    );

    function automatic vec_t mk(logic r, logic [3:0] q, logic rd, logic v,
                                logic [3:0] a, logic [1:0] s, logic b);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = rd; t.ev = v;
        t.eack = a; t.esel = s; t.ebusy = b;
        return t;
    endfunction

    // Drive one cycle of stimulus after the falling edge, then check the outputs
    // mid-cycle, well away from the rising edge.
    task automatic run_vec(input vec_t v, input int idx, input bit use_b);
        logic [7:0] exp_data;
        logic [3:0] a_ack;
        logic [7:0] a_data;
        logic       a_valid, a_busy;
        logic [1:0] a_sel;
        @(negedge clk);
        rst       = v.rst;
        req       = v.req;
        out_ready = v.rdy;
        in0 = {2'd0, 6'(idx)};
        in1 = {2'd1, 6'(idx)};
        in2 = {2'd2, 6'(idx)};
        in3 = {2'd3, 6'(idx)};
        case (v.esel)
            2'd0: exp_data = in0;
            2'd1: exp_data = in1;
            2'd2: exp_data = in2;
            default: exp_data = in3;
        endcase
        #1;
        if (use_b) begin
            a_ack = ack_b; a_data = data_b; a_valid = valid_b; a_busy = busy_b; a_sel = {s1_b, s0_b};
        end else begin
            a_ack = ack_a; a_data = data_a; a_valid = valid_a; a_busy = busy_a; a_sel = {s1_a, s0_a};
        end
        checks += 5;
        if (a_valid !== v.ev) begin
            errors++;
            $display("FAIL vec%0d dut%s out_valid got=%b exp=%b", idx, use_b ? "B" : "A", a_valid, v.ev);
        end
        if (a_ack !== v.eack) begin
            errors++;
            $display("FAIL vec%0d dut%s ack got=%b exp=%b", idx, use_b ? "B" : "A", a_ack, v.eack);
        end
        if (a_sel !== v.esel) begin
            errors++;
            $display("FAIL vec%0d dut%s sel got=%0d exp=%0d", idx, use_b ? "B" : "A", a_sel, v.esel);
        end
        if (a_busy !== v.ebusy) begin
            errors++;
            $display("FAIL vec%0d dut%s busy got=%b exp=%b", idx, use_b ? "B" : "A", a_busy, v.ebusy);
        end
        if (a_data !== exp_data) begin
            errors++;
            $display("FAIL vec%0d dut%s out_data got=%h exp=%h", idx, use_b ? "B" : "A", a_data, exp_data);
        end
        $display("vec%0d dut%s rst=%b req=%b rdy=%b -> valid=%b ack=%b sel=%0d busy=%b data=%h",
                 idx, use_b ? "B" : "A", v.rst, v.req, v.rdy, a_valid, a_ack, a_sel, a_busy, a_data);
    endtask

    initial begin
        // Single requester: grant to 1, four beats, release, bubble, regrant.
        tbl.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 2'd0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0010, 1, 1, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 2'd1, 0));
        tbl.push_back(mk(0, 4'b0010, 1, 1, 4'b0010, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 2'd1, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 2'd1, 0));
        // Reset while idle, then all four requesting: order 0,1,2,3,0.
        tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 2'd1, 0));
        for (int g = 0; g < 4; g++) begin
            tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, (g == 0) ? 2'd0 : 2'(g - 1), 0));
            for (int i = 0; i < 4; i++)
                tbl.push_back(mk(0, 4'b1111, 1, 1, 4'(1 << g), 2'(g), 1));
        end
        tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, 2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0001, 2'd0, 1));
        // Reset during a stalled grant aborts it.
        tbl.push_back(mk(1, 4'b1111, 0, 1, 4'b0000, 2'd0, 1));
        // Early drop: 2 beats from requester 2, then 3 and 0 follow.
        tbl.push_back(mk(0, 4'b0100, 1, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1101, 1, 1, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b1101, 1, 1, 4'b0100, 2'd2, 1));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 4'b0000, 2'd2, 1));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 4'b0000, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1001, 1, 1, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 4'b0000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 4'b0000, 2'd3, 0));
        // Backpressure on requester 0: 1 beat, 3 stalls, 3 more beats.
        tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0001, 2'd0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0001, 0, 1, 4'b0000, 2'd0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0001, 1, 1, 4'b0001, 2'd0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 2'd0, 0));
        // Reset mid-burst from requester 3, then 1010 is granted to 1.
        tbl.push_back(mk(0, 4'b1000, 1, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1000, 1, 1, 4'b1000, 2'd3, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 1, 4'b0000, 2'd3, 1));
        tbl.push_back(mk(0, 4'b1010, 1, 0, 4'b0000, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1010, 1, 1, 4'b0010, 2'd1, 1));

        // Initial reset; no checks before the first reset edge.
        rst = 1'b1; req = 4'd0; out_ready = 1'b0;
        in0 = 8'd0; in1 = 8'd0; in2 = 8'd0; in3 = 8'd0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i, 1'b0);

        // MAX_BURST=1 with req=0101: grants alternate 0,2,0,2 with a bubble between.
        begin
            vec_t v;
            v = mk(1, 4'b0000, 1, 0, 4'b0000, 2'd0, 0);
            @(negedge clk); rst = 1'b1; req = 4'd0;
            @(negedge clk);
            for (int r = 0; r < 4; r++) begin
                v = mk(0, 4'b0101, 1, 0, 4'b0000, (r == 0) ? 2'd0 : ((r % 2 == 1) ? 2'd0 : 2'd2), 0);
                run_vec(v, 100 + 2 * r, 1'b1);
                v = mk(0, 4'b0101, 1, 1, (r % 2 == 0) ? 4'b0001 : 4'b0100, (r % 2 == 0) ? 2'd0 : 2'd2, 1);
                run_vec(v, 101 + 2 * r, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
